// File: rtl/booth_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : booth_sequencer
// Purpose  : Sequential radix-2 Booth multiplier. Signed N-bit multiplicand
//            (operand_a) times signed N-bit multiplier (operand_b) gives a
//            signed 2N-bit product. Each multiplier bit takes one CALC cycle
//            (add/subtract) and one SHIFT cycle (arithmetic right shift).
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active low
//            start      - launch request, sampled only when idle
//            operand_a  - multiplicand M (signed, N bits)
//            operand_b  - multiplier Q (signed, N bits)
//            busy       - high from the cycle after acceptance through DONE
//            done       - one-cycle completion pulse
//            product    - signed 2N-bit result, held until the next DONE
// Revision : 1.0 - initial release
// ============================================================================
module booth_sequencer #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   operand_a,
  input  logic [N-1:0]   operand_b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N:0]       a_q, a_d;
  logic [N:0]       mx_q, mx_d;
  logic [N-1:0]     q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             busy_q, done_q;

  // {A,Q,Q_1} shifted right by one with A's sign bit replicated.
  logic [2*N+1:0]   cat_sh;
  logic [N:0]       a_sh;
  logic [N-1:0]     q_sh;
  logic             q1_sh;

  always_comb begin
    cat_sh = {a_q[N], a_q, q_q};
    a_sh   = cat_sh[2*N+1:N+1];
    q_sh   = cat_sh[N:1];
    q1_sh  = cat_sh[0];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    mx_d      = mx_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // One extra bit on A and Mx keeps -2^(N-1) representable when negated.
          mx_d    = {operand_a[N-1], operand_a};
          q_d     = operand_b;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(N);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        case ({q_q[0], q1_q})
          2'b10:   a_d = a_q - mx_q;
          2'b01:   a_d = a_q + mx_q;
          default: a_d = a_q;
        endcase
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q1_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Capture from the shifted values so product is valid during DONE.
          product_d = {a_sh[N-1:0], q_sh};
          state_d   = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      mx_q      <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      mx_q      <= mx_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      // Status flags are decoded from the next state so they are registered.
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
`default_nettype wire
